// File: rtl/pcm_strobe_fifo_pkg.sv
// Shared constants, types and helpers for the PCM write-strobe FIFO slice.
package pcm_strobe_fifo_pkg;

    localparam int unsigned PCM_DW = 16;
    localparam int unsigned PCM_AW = 3;
    localparam int unsigned PCM_N  = 8;

    typedef enum logic {
        MON_DISARMED = 1'b0,
        MON_ARMED    = 1'b1
    } mon_state_e;

    // Occupancy needs one extra bit so that "full" (2**AW) is representable.
    function automatic int unsigned level_w(input int unsigned aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/pcm_strobe_fifo_if.sv
// Sample-in strobe and valid/ready sample-out bundle of the PCM strobe FIFO.
interface pcm_strobe_fifo_if
    import pcm_strobe_fifo_pkg::*;
#(
    parameter int unsigned DW = PCM_DW
);

    logic          we_pcm;
    logic [DW-1:0] pcm_in;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;

    modport master (
        output we_pcm,
        output pcm_in,
        output rd_ready,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  we_pcm,
        input  pcm_in,
        input  rd_ready,
        output rd_valid,
        output rd_data
    );

endinterface

// File: rtl/pcm_strobe_fifo_period_mon.sv
// Strobe spacing monitor: counts cycles since the last strobe and pulses err_c
// on an early strobe or when the expected strobe fails to show up.
module pcm_period_mon
    import pcm_strobe_fifo_pkg::*;
#(
    parameter int unsigned N = PCM_N
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         strobe,
    input  logic         clr,
    input  logic [N-1:0] exp_period,
    output logic         err_c
);

    localparam logic [N-1:0] IVL_MAX = '1;

    mon_state_e   state_q;
    mon_state_e   state_d;
    logic [N-1:0] ivl;

    // Interval since the last strobe, saturating so a long gap never aliases.
    always_ff @(posedge clk) begin
        if (rst) begin
            ivl <= '0;
        end else if (strobe) begin
            ivl <= N'(1);
        end else if (ivl != IVL_MAX) begin
            ivl <= ivl + N'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MON_DISARMED;
        end else begin
            state_q <= state_d;
        end
    end

    // A late strobe disarms so the following strobe only re-arms instead of also flagging early.
    always_comb begin
        state_d = state_q;
        err_c   = 1'b0;
        case (state_q)
            MON_DISARMED: begin
                if (strobe && !clr) begin
                    state_d = MON_ARMED;
                end
            end
            MON_ARMED: begin
                if (exp_period != '0) begin
                    if (strobe && (ivl != exp_period)) begin
                        err_c = 1'b1;
                    end
                    if (!strobe && (ivl == exp_period)) begin
                        err_c   = 1'b1;
                        state_d = MON_DISARMED;
                    end
                end
                if (clr) begin
                    state_d = MON_DISARMED;
                end
            end
            default: begin
                state_d = MON_DISARMED;
            end
        endcase
    end

endmodule

// File: rtl/pcm_strobe_fifo.sv
// PCM write-strobe consumer: captures strobed samples into a small FIFO with sticky
// overflow; strobe spacing check is built only when PCM_PERIOD_CHECK_EN is defined.
module pcm_strobe_fifo
    import pcm_strobe_fifo_pkg::*;
#(
    parameter int unsigned DW = PCM_DW,
    parameter int unsigned AW = PCM_AW,
    parameter int unsigned N  = PCM_N
)
(
    input  logic                   clk,
    input  logic                   rst,
    pcm_strobe_fifo_if.slave       bus,
    input  logic [N-1:0]           exp_period,
    input  logic                   clr_err,
    output logic [level_w(AW)-1:0] level,
    output logic                   overflow,
    output logic                   strobe_err
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = level_w(AW);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_valid_q;
    logic [LW-1:0] level_nxt_c;
    logic          full_c;
    logic          pop_c;
    logic          push_c;
    logic          ovf_evt_c;

    assign full_c    = (level == LW'(DEPTH));
    assign pop_c     = rd_valid_q && bus.rd_ready;
    assign push_c    = bus.we_pcm && (!full_c || pop_c);
    assign ovf_evt_c = bus.we_pcm && full_c && !pop_c;

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = mem[rd_ptr];

    always_comb begin
        level_nxt_c = level;
        case ({push_c, pop_c})
            2'b10:   level_nxt_c = level + LW'(1);
            2'b01:   level_nxt_c = level - LW'(1);
            default: level_nxt_c = level;
        endcase
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= bus.pcm_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level      <= level_nxt_c;
            rd_valid_q <= (level_nxt_c != '0);
        end
    end

    // Sticky flags: a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= (overflow && !clr_err) || ovf_evt_c;
        end
    end

`ifdef PCM_PERIOD_CHECK_EN
    logic serr_evt_c;

    pcm_period_mon #(
        .N (N)
    ) u_period_mon (
        .clk        (clk),
        .rst        (rst),
        .strobe     (bus.we_pcm),
        .clr        (clr_err),
        .exp_period (exp_period),
        .err_c      (serr_evt_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_err <= 1'b0;
        end else begin
            strobe_err <= (strobe_err && !clr_err) || serr_evt_c;
        end
    end
`else
    logic unused_exp_period;

    assign unused_exp_period = ^exp_period;
    assign strobe_err        = 1'b0;
`endif

endmodule

// File: tb/tb_pcm_strobe_fifo.sv
// Scoreboard bench for pcm_strobe_fifo: directed scenarios plus a randomized soak
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_pcm_strobe_fifo;
    import pcm_strobe_fifo_pkg::*;

    localparam int unsigned DW    = PCM_DW;
    localparam int unsigned AW    = PCM_AW;
    localparam int unsigned N     = PCM_N;
    localparam int          DEPTH = 1 << AW;
    localparam int unsigned IVL_SAT = (1 << N) - 1;
`ifdef PCM_PERIOD_CHECK_EN
    localparam bit PERIOD_EN = 1'b1;
`else
    localparam bit PERIOD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  exp_period = '0;
    logic          clr_err = 1'b0;
    logic [AW:0]   level;
    logic          overflow;
    logic          strobe_err;

    pcm_strobe_fifo_if #(.DW(DW)) bus();

    pcm_strobe_fifo #(.DW(DW), .AW(AW), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .exp_period (exp_period),
        .clr_err    (clr_err),
        .level      (level),
        .overflow   (overflow),
        .strobe_err (strobe_err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    bit            mon_en = 1'b0;
    int            m_level = 0;
    bit            m_ovf = 1'b0;
    bit            m_serr = 1'b0;
    bit            m_armed = 1'b0;
    int unsigned   m_cyc = 0;
    int unsigned   m_last = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: occupancy count, sample queue and strobe timestamps.
    function automatic void model_update(bit we, logic [DW-1:0] d, bit rdy, bit clr, bit r);
        int unsigned gap;
        bit pop, ok, late, evt;
        m_cyc++;
        if (r) begin
            m_level = 0;
            exp_q.delete();
            m_ovf = 1'b0;
            m_serr = 1'b0;
            m_armed = 1'b0;
            return;
        end
        pop = (m_level > 0) && rdy;
        ok  = we && ((m_level < DEPTH) || pop);
        gap = m_cyc - m_last;
        if (gap > IVL_SAT) gap = IVL_SAT;
        evt  = 1'b0;
        late = 1'b0;
        if (PERIOD_EN && m_armed && (exp_period != '0)) begin
            if (we && (gap != int'(exp_period))) evt = 1'b1;
            if (!we && (gap == int'(exp_period))) begin
                evt  = 1'b1;
                late = 1'b1;
            end
        end
        if (clr || late) m_armed = 1'b0;
        else if (we)     m_armed = 1'b1;
        if (we) m_last = m_cyc;
        m_ovf  = (m_ovf && !clr) || (we && !ok);
        m_serr = (m_serr && !clr) || evt;
        if (pop) m_level--;
        if (ok) begin
            m_level++;
            exp_q.push_back(d);
        end
    endfunction

    task automatic step(input bit we, input logic [DW-1:0] d, input bit rdy, input bit clr, input bit r);
        bus.we_pcm   = we;
        bus.pcm_in   = d;
        bus.rd_ready = rdy;
        clr_err      = clr;
        rst          = r;
        @(posedge clk);
        #1;
        model_update(we, d, rdy, clr, r);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(1'b0, '0, rdy, 1'b0, 1'b0);
    endtask

    // Monitor: status against the model every cycle, data against the scoreboard on each pop.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("level", 32'(level), 32'(m_level));
                chk("rd_valid", 32'(bus.rd_valid), 32'(m_level != 0));
                chk("overflow", 32'(overflow), 32'(m_ovf));
                chk("strobe_err", 32'(strobe_err), 32'(m_serr));
                if (bus.rd_valid && bus.rd_ready && !rst) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_data act=%0h exp=<none> t=%0t", bus.rd_data, $time);
                    end else begin
                        chk("rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int per;
        int cnt;
        int rdy_pct;
        bit we;
        bus.we_pcm   = 1'b0;
        bus.pcm_in   = '0;
        bus.rd_ready = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_flags", 32'({overflow, strobe_err}), 32'd0);

        // Period 4, in-order delivery one cycle after each strobe.
        exp_period = N'(4);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        for (int v = 1; v <= 3; v++) begin
            step(1'b1, DW'(v), 1'b1, 1'b0, 1'b0);
            chk("t1_valid_after_strobe", 32'(bus.rd_valid), 32'd1);
            chk("t1_head", 32'(bus.rd_data), 32'(v));
            idle(3, 1'b1);
        end
        chk("t1_strobe_err", 32'(strobe_err), 32'd0);
        exp_period = '0;
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Fill past capacity with the reader stalled, then drain.
        for (int v = 10; v <= 18; v++) step(1'b1, DW'(v), 1'b0, 1'b0, 1'b0);
        chk("t2_level_full", 32'(level), 32'(DEPTH));
        chk("t2_overflow", 32'(overflow), 32'd1);
        idle(DEPTH, 1'b1);
        chk("t2_level_empty", 32'(level), 32'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t2_overflow_clr", 32'(overflow), 32'd0);

        // Full with a strobe coincident with a pop.
        for (int v = 20; v < 20 + DEPTH; v++) step(1'b1, DW'(v), 1'b0, 1'b0, 1'b0);
        step(1'b1, DW'(99), 1'b1, 1'b0, 1'b0);
        chk("t3_level", 32'(level), 32'(DEPTH));
        chk("t3_overflow", 32'(overflow), 32'd0);
        idle(DEPTH, 1'b1);
        chk("t3_drained", 32'(level), 32'd0);

        // Early strobe: spacing 5,5,3 with exp_period 5.
        exp_period = N'(5);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b1, DW'(40), 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);
        step(1'b1, DW'(41), 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);
        step(1'b1, DW'(42), 1'b1, 1'b0, 1'b0);
        chk("t4_before_early", 32'(strobe_err), 32'd0);
        idle(2, 1'b1);
        step(1'b1, DW'(43), 1'b1, 1'b0, 1'b0);
        chk("t4_early", 32'(strobe_err), 32'(PERIOD_EN));

        // Missing strobe after arming, clear, then clean re-arm.
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("t5_cleared", 32'(strobe_err), 32'd0);
        step(1'b1, DW'(50), 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);
        chk("t5_not_yet_late", 32'(strobe_err), 32'd0);
        idle(1, 1'b1);
        chk("t5_late", 32'(strobe_err), 32'(PERIOD_EN));
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("t5_clr", 32'(strobe_err), 32'd0);
        step(1'b1, DW'(51), 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);
        step(1'b1, DW'(52), 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1);
        step(1'b1, DW'(53), 1'b1, 1'b0, 1'b0);
        chk("t5_rearm_clean", 32'(strobe_err), 32'd0);
        exp_period = '0;
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Reset mid-stream discards buffered samples.
        for (int v = 60; v < 65; v++) step(1'b1, DW'(v), 1'b0, 1'b0, 1'b0);
        chk("t6_level5", 32'(level), 32'd5);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("t6_level", 32'(level), 32'd0);
        chk("t6_valid", 32'(bus.rd_valid), 32'd0);
        chk("t6_flags", 32'({overflow, strobe_err}), 32'd0);

        // Randomized soak: mostly periodic strobes with jitter, varying reader duty.
        per = 4;
        cnt = 0;
        rdy_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                per = int'($urandom_range(2, 7));
                case ($urandom_range(0, 3))
                    0:       exp_period = '0;
                    1:       exp_period = N'(per + 1);
                    default: exp_period = N'(per);
                endcase
                case ($urandom_range(0, 3))
                    0:       rdy_pct = 5;
                    1:       rdy_pct = 15;
                    2:       rdy_pct = 30;
                    default: rdy_pct = 70;
                endcase
            end
            cnt++;
            we = 1'b0;
            if (cnt >= per) begin
                cnt = 0;
                we  = ($urandom_range(0, 19) != 0);
            end else if ($urandom_range(0, 29) == 0) begin
                we = 1'b1;
            end
            step(we, DW'($urandom), (int'($urandom_range(0, 99)) < rdy_pct),
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 999) == 0));
        end

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
